// File: rtl/debug_uart_tx.sv
// debug_uart_tx
//   Sends the CPU debug bytes to the host debugger over a transmit-only UART (8N1).
//   A start request takes a snapshot of debug_port1..7. The frame is sent as
//   SYNC_BYTE followed by the seven snapshot bytes, with no idle gap between bytes.
//
// Optional build macro: DEBUG_UART_CHECKSUM_EN
//   When defined, a ninth byte is sent after the seven data bytes. It is the XOR of
//   the seven snapshot bytes; SYNC_BYTE is not included.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per UART bit (2..65535)
//   SYNC_BYTE    : header byte sent at the start of every frame
//
// Ports
//   clk                       : system clock, rising edge
//   rst                       : asynchronous, active-high reset
//   start                     : single-cycle request to snapshot and send one frame
//   debug_port1..debug_port7  : debug bytes to snapshot
//   tx                        : UART serial line, idles high
//   busy                      : high while a frame is being sent
//   done                      : one-cycle pulse after the last stop bit
//
// state      | meaning
// -----------+--------------------------------------------------
// S_IDLE     | line idles high, waiting for start
// S_START_BIT| driving the start bit (0) of the current byte
// S_DATA     | driving data bits LSB first, r_bit_idx selects the bit
// S_STOP_BIT | driving the stop bit (1), then next byte or finish

module debug_uart_tx #(
   parameter int          CLKS_PER_BIT = 434,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] debug_port1,
   input  logic [7:0] debug_port2,
   input  logic [7:0] debug_port3,
   input  logic [7:0] debug_port4,
   input  logic [7:0] debug_port5,
   input  logic [7:0] debug_port6,
   input  logic [7:0] debug_port7,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam logic [15:0] LP_BAUD_LAST = 16'(CLKS_PER_BIT - 1);
`ifdef DEBUG_UART_CHECKSUM_EN
   localparam logic [3:0]  LP_LAST_BYTE = 4'd8;
`else
   localparam logic [3:0]  LP_LAST_BYTE = 4'd7;
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_START_BIT,
      S_DATA,
      S_STOP_BIT
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_baud;
   logic [2:0]  r_bit_idx;
   logic [3:0]  r_byte_idx;
   logic [7:0]  r_snap1, r_snap2, r_snap3, r_snap4, r_snap5, r_snap6, r_snap7;
   logic        r_done;
   logic        w_bit_end;
   logic [7:0]  w_cur_byte;
   logic        w_tx;

   assign w_bit_end = (r_baud == LP_BAUD_LAST);

`ifdef DEBUG_UART_CHECKSUM_EN
   logic [7:0] w_checksum;
   assign w_checksum = r_snap1 ^ r_snap2 ^ r_snap3 ^ r_snap4 ^ r_snap5 ^ r_snap6 ^ r_snap7;
`endif

   always_comb begin
      w_cur_byte = SYNC_BYTE;
      case (r_byte_idx)
         4'd1:    w_cur_byte = r_snap1;
         4'd2:    w_cur_byte = r_snap2;
         4'd3:    w_cur_byte = r_snap3;
         4'd4:    w_cur_byte = r_snap4;
         4'd5:    w_cur_byte = r_snap5;
         4'd6:    w_cur_byte = r_snap6;
         4'd7:    w_cur_byte = r_snap7;
`ifdef DEBUG_UART_CHECKSUM_EN
         4'd8:    w_cur_byte = w_checksum;
`endif
         default: w_cur_byte = SYNC_BYTE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tx        = 1'b1;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_nxt = S_START_BIT;
         end
         S_START_BIT: begin
            w_tx = 1'b0;
            if (w_bit_end) w_state_nxt = S_DATA;
         end
         S_DATA: begin
            w_tx = w_cur_byte[r_bit_idx];
            if (w_bit_end && (r_bit_idx == 3'd7)) w_state_nxt = S_STOP_BIT;
         end
         S_STOP_BIT: begin
            if (w_bit_end) w_state_nxt = (r_byte_idx < LP_LAST_BYTE) ? S_START_BIT : S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Timing: tx depends only on registered state, so the start bit appears on the
   // same edge that accepts start, and a reset forces the line high right away.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_baud     <= 16'd0;
         r_bit_idx  <= 3'd0;
         r_byte_idx <= 4'd0;
         r_done     <= 1'b0;
         r_snap1    <= 8'd0;
         r_snap2    <= 8'd0;
         r_snap3    <= 8'd0;
         r_snap4    <= 8'd0;
         r_snap5    <= 8'd0;
         r_snap6    <= 8'd0;
         r_snap7    <= 8'd0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_baud     <= 16'd0;
               r_bit_idx  <= 3'd0;
               r_byte_idx <= 4'd0;
               if (start) begin
                  r_snap1 <= debug_port1;
                  r_snap2 <= debug_port2;
                  r_snap3 <= debug_port3;
                  r_snap4 <= debug_port4;
                  r_snap5 <= debug_port5;
                  r_snap6 <= debug_port6;
                  r_snap7 <= debug_port7;
               end
            end
            S_START_BIT: begin
               r_baud <= w_bit_end ? 16'd0 : r_baud + 16'd1;
            end
            S_DATA: begin
               r_baud <= w_bit_end ? 16'd0 : r_baud + 16'd1;
               // The 3-bit index wraps 7 -> 0, so it is already 0 for the next byte.
               if (w_bit_end) r_bit_idx <= r_bit_idx + 3'd1;
            end
            S_STOP_BIT: begin
               r_baud <= w_bit_end ? 16'd0 : r_baud + 16'd1;
               if (w_bit_end) begin
                  if (r_byte_idx < LP_LAST_BYTE) begin
                     r_byte_idx <= r_byte_idx + 4'd1;
                  end else begin
                     r_byte_idx <= 4'd0;
                     r_done     <= 1'b1;
                  end
               end
            end
            default: r_baud <= 16'd0;
         endcase
      end
   end

   assign tx   = w_tx;
   assign busy = (r_state != S_IDLE);
   assign done = r_done;

endmodule

// File: tb/tb_debug_uart_tx.sv
module tb_debug_uart_tx;

   localparam int         CPB  = 4;
   localparam logic [7:0] SYNC = 8'hA5;
`ifdef DEBUG_UART_CHECKSUM_EN
   localparam int         NB   = 9;
`else
   localparam int         NB   = 8;
`endif
   localparam int         FRAME_CYC = 10 * NB * CPB;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] dp [7];
   logic       tx, busy, done;

   int checks   = 0;
   int errors   = 0;
   int done_cnt = 0;
   int exp_done = 0;
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   debug_uart_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(SYNC)) dut (
      .clk(clk), .rst(rst), .start(start),
      .debug_port1(dp[0]), .debug_port2(dp[1]), .debug_port3(dp[2]),
      .debug_port4(dp[3]), .debug_port5(dp[4]), .debug_port6(dp[5]),
      .debug_port7(dp[6]),
      .tx(tx), .busy(busy), .done(done)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: a frame is the sync byte, the seven port bytes, and optionally
   // their XOR.
   function automatic void push_frame(input logic [55:0] v);
      logic [7:0] x;
      x = 8'h00;
      exp_q.push_back(SYNC);
      for (int i = 0; i < 7; i++) begin
         exp_q.push_back(v[8*i +: 8]);
         x = x ^ v[8*i +: 8];
      end
      if (NB == 9) exp_q.push_back(x);
   endfunction

   // UART receiver: collects 40 samples per byte (10 bits x 4 cycles). Every sample
   // within a bit period must have the same value.
   initial begin
      int         n;
      logic [39:0] buff;
      logic [7:0]  data;
      logic        ok;
      logic [7:0]  e;
      n = 0;
      buff = '0;
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            n = 0;
            exp_q.delete();
         end else if (!(n == 0 && tx === 1'b1)) begin
            buff[n] = tx;
            n++;
            if (n == 40) begin
               n = 0;
               ok = 1'b1;
               data = 8'h00;
               for (int k = 0; k < 10; k++) begin
                  for (int j = 1; j < CPB; j++)
                     if (buff[CPB*k+j] !== buff[CPB*k]) ok = 1'b0;
                  if (k == 0 && buff[0] !== 1'b0) ok = 1'b0;
                  if (k == 9 && buff[CPB*9] !== 1'b1) ok = 1'b0;
                  if (k >= 1 && k <= 8) data[k-1] = buff[CPB*k];
               end
               chk("bit_framing", {31'd0, ok}, 32'd1);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_byte: got 0x%0h, expected no byte", data);
               end else begin
                  e = exp_q.pop_front();
                  chk("byte_value", {24'd0, data}, {24'd0, e});
               end
            end
         end
      end
   end

   // Busy/done monitor: busy must last exactly one frame, and done must appear in the
   // cycle in which busy falls.
   initial begin
      int b_cnt;
      b_cnt = 0;
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            b_cnt = 0;
         end else begin
            if (done === 1'b1) done_cnt++;
            if (busy === 1'b1) begin
               b_cnt++;
            end else if (b_cnt > 0) begin
               chk("busy_length", b_cnt, FRAME_CYC);
               chk("done_at_busy_fall", {31'd0, done}, 32'd1);
               b_cnt = 0;
            end
         end
      end
   end

   task automatic issue(input logic [55:0] v);
      for (int i = 0; i < 7; i++) dp[i] = v[8*i +: 8];
      start = 1'b1;
      push_frame(v);
      exp_done++;
      @(posedge clk);
      #1;
      chk("start_bit_latency", {31'd0, tx}, 32'd0);
      chk("busy_rise", {31'd0, busy}, 32'd1);
      #1;
      start = 1'b0;
   endtask

   task automatic send(input logic [55:0] v);
      @(posedge clk);
      #2;
      issue(v);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (n < 2000) begin
         @(negedge clk);
         if (done === 1'b1) break;
         n++;
      end
      chk("done_timeout", {31'd0, (n < 2000)}, 32'd1);
   endtask

   task automatic poke_start();
      @(posedge clk);
      #2;
      start = 1'b1;
      @(posedge clk);
      #2;
      start = 1'b0;
   endtask

   localparam logic [55:0] PORTS_A = {8'h10, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};

   initial begin
      rst = 1'b1;
      start = 1'b0;
      for (int i = 0; i < 7; i++) dp[i] = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_tx", {31'd0, tx}, 32'd1);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      #1;
      rst = 1'b0;

      // The line must stay idle while no start is given.
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         chk("idle_hold", {29'd0, tx, busy, done}, 32'b100);
      end

      // Send one frame with fixed ports. Change the inputs one cycle after start so the
      // test shows that the frame uses the snapshot.
      send(PORTS_A);
      for (int i = 0; i < 7; i++) dp[i] = 8'hFF;
      wait_done();

      // Start requests made while busy must be ignored.
      send(PORTS_A);
      repeat (47) @(posedge clk);
      for (int i = 0; i < 7; i++) dp[i] = 8'($urandom);
      poke_start();
      repeat (148) @(posedge clk);
      poke_start();
      wait_done();
      repeat (20) @(negedge clk);
      chk("no_extra_frame", {31'd0, busy}, 32'd0);

      // Reset in the middle of a frame.
      send(PORTS_A);
      repeat (98) @(posedge clk);
      #2;
      rst = 1'b1;
      exp_done--;
      #1;
      chk("midrst_tx", {31'd0, tx}, 32'd1);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      repeat (5) @(posedge clk);
      send(PORTS_A);
      wait_done();

      // Random frames. Every other frame starts in the done cycle of the previous frame.
      send({$urandom, $urandom});
      for (int r = 0; r < 6; r++) begin
         wait_done();
         if (r % 2 == 0) begin
            #2;
            issue({$urandom, $urandom});
         end else begin
            send({$urandom, $urandom});
         end
      end
      wait_done();

      repeat (20) @(negedge clk);
      chk("queue_drained", exp_q.size(), 32'd0);
      chk("done_count", done_cnt, exp_done);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
